write_buffer_multi: RTL and testbench
=====================================

# write_buffer_multi

Multi-entry successor to the single-line data-cache write buffer. Holds up to `DEPTH` evicted dirty lines in a FIFO and drains them in order as AXI3 INCR bursts. Serves combinational hit lookups so the D-cache can re-read or byte-merge into lines still waiting. Sits between the D-cache victim path and the AXI3 write channel (`awid`/`wid` = `AWID`).

## Interface
Parameters:
- `LINE_WIDTH`, 256, line data bits; multiple of 32, ≥64.
- `DEPTH`, 4, number of line entries; power of two, ≥2.
- `AWID`, 1, AXI ID driven on `awid` and `wid`.
- Derived: `LINE_BYTE_OFFSET = clog2(LINE_WIDTH/8)`; `LABEL_WIDTH = 32 - LINE_BYTE_OFFSET`; `BURST_LIMIT = LINE_WIDTH/32 - 1`.

Ports:
- `clk`, in, 1, clock. One clock; reset is asynchronous and active-high.
- `rst`, in, 1, asynchronous active-high reset.
- `axi3_wr_if`, master, `axi3_wr_if`, AXI3 write address/data/response channels.
- `pline`, in, `LABEL_WIDTH+LINE_WIDTH`, `{label, data}` to enqueue.
- `push`, in, 1, enqueue request.
- `pushed`, out, 1, push accepted this cycle; equals `push & ~full`.
- `full`, out, 1, all `DEPTH` entries valid.
- `empty`, out, 1, no valid entries and drain FSM in `WB_IDLE`.
- `query_label`, in, `LABEL_WIDTH`, lookup label.
- `query_found`, out, 1, a valid entry matches.
- `query_rdata`, out, `LINE_WIDTH`, data of the matching entry; `'0` when no entry matches.
- `query_wdata`, in, `LINE_WIDTH`, merge data.
- `query_wbe`, in, `LINE_WIDTH/8`, merge byte enables.
- `write`, in, 1, merge request.
- `written`, out, 1, merge accepted this cycle.

## Operation
- **Storage.** Circular FIFO with `head` and `tail` pointers of `clog2(DEPTH)` bits, which wrap naturally, plus a count of `clog2(DEPTH)+1` bits. Each entry holds a valid bit, label and data.
- **Push.** When `pushed`, `pline` is written at `tail`, then `tail` and count increment.
- **Query.**
  - Combinational compare of `query_label` against all valid entries.
  - On multiple matches, the youngest match wins (closest to `tail`).
- **Lock.** The `head` entry is locked whenever the FSM is not in `WB_IDLE`.
- **Merge.**
  - `written = write & query_found & ~locked(match) & ~(pushed & coalesce-target==match)`.
  - When `written`, only the bytes with `query_wbe` set are replaced by `query_wdata`.
  - When `write` is high but `written` is 0, the caller retries.
- **Drain FSM.** States `WB_IDLE`, `WB_WAIT_AWREADY`, `WB_WRITE`, `WB_WAIT_BVALID`.
  - `WB_IDLE`: when count≠0, go to `WB_WAIT_AWREADY`. The beat counter is cleared.
  - `WB_WAIT_AWREADY`: `awvalid`=1 and `awaddr={head.label, 0}`. On `awready`, go to `WB_WRITE`.
  - `WB_WRITE`: `wvalid`=1 and `wdata` = 32-bit beat[counter] of head data. The counter increments on `wready`. `wlast` = (counter==`BURST_LIMIT`). On `wready & wlast`, go to `WB_WAIT_BVALID`.
  - `WB_WAIT_BVALID`: on `bvalid` (`bresp` ignored), clear head valid, increment `head`, decrement count, go to `WB_IDLE`.
- **Fixed AXI fields.**
  - `awlen=BURST_LIMIT`, `awsize=3'b010`, `awburst=2'b01`.
  - `awlock`, `awprot`, `awcache` all `'0`.
  - `wstrb=4'hF`, `bready=1`.
- **Simultaneous push and pop** in one cycle: count is unchanged. `full` is computed from the registered count, so a push made while full is refused even if a pop happens in the same cycle.

## Timing
- **Reset** (async, takes effect immediately):
  - state `WB_IDLE`; pointers, count and all valid bits cleared.
  - Outputs: `full`=0, `empty`=1, `query_found`=0, `written`=0, `awvalid`=0, `wvalid`=0, `bready`=1. `pushed` follows `push` once reset is released.
  - Asserting `rst` mid-burst abandons the burst; all entries are lost.
- **Push-to-query.** An entry pushed at edge N is visible to query at cycle N+1.
- **Push-to-drain.** If the buffer was empty when the push is accepted in cycle N, `awvalid` is first high in cycle N+2.
- **Burst.** Exactly `BURST_LIMIT+1` beats, one per `wready` cycle. `wvalid` stays high and `wdata` stays stable while `wready`=0.
- **Entry freed.** An entry becomes free on the edge that samples `bvalid`. `full` drops in the following cycle.
- **Merge.** A merge with `written` at edge N is visible in `query_rdata` at N+1 and in the drained data.

## Configuration
- `WB_COALESCE_EN` defined:
  - A push whose label matches an unlocked valid entry overwrites that entry's data in place. No allocation; count is unchanged.
  - Such a push is accepted even when `full`, so `pushed = push & (~full | coalesce-hit)`.
  - At most one entry per label exists.
- `WB_COALESCE_EN` undefined:
  - Every push allocates a new entry; duplicate labels are allowed.
  - Query and merge use the youngest match.
  - The coalesce term in `written` is 0.

## Test plan
- Push 4 lines (`DEPTH`=4) with labels 0x10–0x13 while `awready`=0 → `full`=1; a 5th push gives `pushed`=0; `awaddr` = 0x10<<5.
- Full drain with `awready`, `wready`, `bvalid` always 1 → bursts leave in order 0x10…0x13, each 8 beats with `wlast` on beat 7; `empty`=1 afterwards.
- Merge `query_wbe`=0x0000000F with `query_wdata`=all 0xAA into a queued, unlocked line → `written`=1; the drained beat 0 is 0xAAAAAAAA and the other beats are unchanged.
- Merge to the head while in `WB_WRITE` → `written`=0, `query_found`=1; data unchanged.
- Push 0x20 twice with different data → with `WB_COALESCE_EN`, count=1 and one burst carrying the second data; without it, count=2 and two bursts.
- Assert `rst` mid-burst at beat 3 → `wvalid`=0 and `empty`=1 immediately; no AXI activity afterwards.

Source files
------------

// File: rtl/write_buffer_multi_if.sv
// axi3_wr_if: AXI3 write address, write data and write response channels
// (32-bit data, 4-bit IDs) shared by the write buffer and its AXI slave.
interface axi3_wr_if;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   // Every channel transfers on a clock edge where valid and ready are both high;
   // a raised valid and its payload hold until that edge.
   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/write_buffer_multi.sv
// write_buffer_multi: DEPTH-entry FIFO of evicted dirty lines drained in order as AXI3 INCR
// bursts, with combinational hit lookup and byte merge. Define WB_COALESCE_EN for in-place push coalescing.
module write_buffer_multi #(
   parameter int LINE_WIDTH = 256,
   parameter int DEPTH = 4,
   parameter int AWID = 1,
   localparam int LINE_BYTE_OFFSET = $clog2(LINE_WIDTH/8),
   localparam int LABEL_WIDTH = 32 - LINE_BYTE_OFFSET,
   localparam int BURST_LIMIT = LINE_WIDTH/32 - 1
) (
   input  logic                              clk,
   input  logic                              rst,
   axi3_wr_if.master                         axi3_wr_if,
   input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] pline,
   input  logic                              push,
   output logic                              pushed,
   output logic                              full,
   output logic                              empty,
   input  logic [LABEL_WIDTH-1:0]            query_label,
   output logic                              query_found,
   output logic [LINE_WIDTH-1:0]             query_rdata,
   input  logic [LINE_WIDTH-1:0]             query_wdata,
   input  logic [LINE_WIDTH/8-1:0]           query_wbe,
   input  logic                              write,
   output logic                              written,
   output logic [1:0]                        dbg_state
);
   localparam int PW = $clog2(DEPTH);
   localparam int BW = $clog2(BURST_LIMIT + 1);
   localparam int NB = LINE_WIDTH/8;

   typedef enum logic [1:0] {WB_IDLE, WB_WAIT_AWREADY, WB_WRITE, WB_WAIT_BVALID} wb_state_t;

   wb_state_t               state_q, state_d;
   logic [BW-1:0]           beat_q, beat_d;
   logic [PW-1:0]           head_q, tail_q;
   logic [PW:0]             count_q;
   logic [DEPTH-1:0]        valid_q;
   logic [LABEL_WIDTH-1:0]  label_q [DEPTH];
   logic [LINE_WIDTH-1:0]   data_q  [DEPTH];

   logic                    q_found, q_locked;
   logic [PW-1:0]           q_idx;
   logic [LINE_WIDTH-1:0]   merged, head_data;
   logic                    coal_hit, alloc, pop;
   logic                    awvalid, wvalid, wlast;

   // Scan from head (oldest) to tail so the youngest match overrides older ones.
   always_comb begin
      q_found = 1'b0;
      q_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (valid_q[head_q + PW'(k)] && label_q[head_q + PW'(k)] == query_label) begin
            q_found = 1'b1;
            q_idx   = head_q + PW'(k);
         end
      end
   end

   assign q_locked    = (state_q != WB_IDLE) && (q_idx == head_q);
   assign query_found = q_found;
   assign query_rdata = q_found ? data_q[q_idx] : '0;
   assign full        = (count_q == (PW+1)'(DEPTH));
   assign empty       = (count_q == '0) && (state_q == WB_IDLE);

   always_comb begin
      merged = data_q[q_idx];
      for (int b = 0; b < NB; b++) begin
         if (query_wbe[b]) merged[8*b +: 8] = query_wdata[8*b +: 8];
      end
   end

`ifdef WB_COALESCE_EN
   logic          p_found, p_locked;
   logic [PW-1:0] p_idx;

   always_comb begin
      p_found = 1'b0;
      p_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (valid_q[head_q + PW'(k)] &&
             label_q[head_q + PW'(k)] == pline[LINE_WIDTH +: LABEL_WIDTH]) begin
            p_found = 1'b1;
            p_idx   = head_q + PW'(k);
         end
      end
   end

   assign p_locked = (state_q != WB_IDLE) && (p_idx == head_q);
   assign coal_hit = push & p_found & ~p_locked;
   assign pushed   = push & (~full | coal_hit);
   assign written  = write & q_found & ~q_locked & ~(coal_hit & (p_idx == q_idx));
`else
   assign coal_hit = 1'b0;
   assign pushed   = push & ~full;
   assign written  = write & q_found & ~q_locked;
`endif

   assign alloc = pushed & ~coal_hit;
   assign pop   = (state_q == WB_WAIT_BVALID) & axi3_wr_if.bvalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (alloc) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PW'(1);
         end
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PW'(1);
         end
         count_q <= count_q + (PW+1)'(alloc) - (PW+1)'(pop);
      end
   end

   // Payload needs no reset: valid_q alone decides whether an entry means anything.
   always_ff @(posedge clk) begin
      if (alloc) begin
         label_q[tail_q] <= pline[LINE_WIDTH +: LABEL_WIDTH];
         data_q[tail_q]  <= pline[LINE_WIDTH-1:0];
      end
`ifdef WB_COALESCE_EN
      if (coal_hit) data_q[p_idx] <= pline[LINE_WIDTH-1:0];
`endif
      if (written) data_q[q_idx] <= merged;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WB_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wlast   = 1'b0;
      case (state_q)
         WB_IDLE: begin
            beat_d = '0;
            if (count_q != '0) state_d = WB_WAIT_AWREADY;
         end
         WB_WAIT_AWREADY: begin
            awvalid = 1'b1;
            if (axi3_wr_if.awready) state_d = WB_WRITE;
         end
         WB_WRITE: begin
            wvalid = 1'b1;
            wlast  = (beat_q == BW'(BURST_LIMIT));
            if (axi3_wr_if.wready) begin
               beat_d = beat_q + BW'(1);
               if (wlast) state_d = WB_WAIT_BVALID;
            end
         end
         WB_WAIT_BVALID: begin
            if (axi3_wr_if.bvalid) state_d = WB_IDLE;
         end
         default: state_d = WB_IDLE;
      endcase
   end

   assign head_data = data_q[head_q];
   assign dbg_state = state_q;

   assign axi3_wr_if.awid    = 4'(AWID);
   assign axi3_wr_if.awaddr  = {label_q[head_q], {LINE_BYTE_OFFSET{1'b0}}};
   assign axi3_wr_if.awlen   = 4'(BURST_LIMIT);
   assign axi3_wr_if.awsize  = 3'b010;
   assign axi3_wr_if.awburst = 2'b01;
   assign axi3_wr_if.awlock  = '0;
   assign axi3_wr_if.awcache = '0;
   assign axi3_wr_if.awprot  = '0;
   assign axi3_wr_if.awvalid = awvalid;
   assign axi3_wr_if.wid     = 4'(AWID);
   assign axi3_wr_if.wdata   = head_data[{beat_q, 5'd0} +: 32];
   assign axi3_wr_if.wstrb   = 4'hF;
   assign axi3_wr_if.wlast   = wlast;
   assign axi3_wr_if.wvalid  = wvalid;
   assign axi3_wr_if.bready  = 1'b1;

   logic unused_bresp;
   assign unused_bresp = ^{axi3_wr_if.bid, axi3_wr_if.bresp};
endmodule

// File: tb/tb_write_buffer_multi.sv
// tb_write_buffer_multi: directed and randomized checks of write_buffer_multi against a
// queue model of buffered lines and the bursts they should produce.
module tb_write_buffer_multi;
   localparam int LW   = 256;
   localparam int D    = 4;
   localparam int LBW  = 27;
   localparam int NB   = LW/8;
   localparam int ALLW = LBW + LW;

   logic            clk = 1'b0;
   logic            rst;
   logic [ALLW-1:0] pline;
   logic            push, pushed, full, empty;
   logic [LBW-1:0]  query_label;
   logic            query_found;
   logic [LW-1:0]   query_rdata, query_wdata;
   logic [NB-1:0]   query_wbe;
   logic            write, written;
   logic [1:0]      dbg_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi3_wr_if axi();

   write_buffer_multi #(.LINE_WIDTH(LW), .DEPTH(D), .AWID(1)) dut (
      .clk(clk), .rst(rst), .axi3_wr_if(axi),
      .pline(pline), .push(push), .pushed(pushed), .full(full), .empty(empty),
      .query_label(query_label), .query_found(query_found), .query_rdata(query_rdata),
      .query_wdata(query_wdata), .query_wbe(query_wbe), .write(write), .written(written),
      .dbg_state(dbg_state)
   );

   logic [ALLW-1:0] mdl_q[$];
   logic [ALLW-1:0] exp_q[$];
   logic [31:0]     got_addr_q[$];
   logic [LW-1:0]   got_data_q[$];
   int              got_beats_q[$];
   int              got_last_q[$];

   int              mode;
   int              beat_i;
   int              aw_cycles;

   task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave: mode 0 idle, 1 always ready, 2 random, 3 address only. Records bursts.
   initial begin
      logic [LW-1:0] cur_line;
      logic [31:0]   cur_addr;
      logic [31:0]   held;
      bit            hold_pending;
      int            last_pos;
      cur_line = '0; cur_addr = '0; held = '0; hold_pending = 0; last_pos = -1;
      axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00; axi.bid = 4'd1;
      forever begin
         @(negedge clk);
         case (mode)
            1:       begin axi.awready = 1; axi.wready = 1; axi.bvalid = 1; end
            2:       begin
                        axi.awready = 1'($urandom_range(0, 1));
                        axi.wready  = 1'($urandom_range(0, 1));
                        axi.bvalid  = 1'($urandom_range(0, 1));
                     end
            3:       begin axi.awready = 1; axi.wready = 0; axi.bvalid = 0; end
            default: begin axi.awready = 0; axi.wready = 0; axi.bvalid = 0; end
         endcase
         #1;
         if (rst) begin
            hold_pending = 0;
         end else begin
            if (hold_pending && axi.wvalid) check("wdata_stable", axi.wdata, held);
            hold_pending = axi.wvalid && !axi.wready;
            held = axi.wdata;
            if (axi.awvalid) aw_cycles++;
            if (axi.awvalid && axi.awready) begin
               cur_addr = axi.awaddr; beat_i = 0; last_pos = -1;
            end
            if (axi.wvalid && axi.wready) begin
               if (beat_i < LW/32) cur_line[32*beat_i +: 32] = axi.wdata;
               if (axi.wlast) last_pos = beat_i;
               beat_i++;
               if (axi.wlast) begin
                  got_addr_q.push_back(cur_addr);
                  got_data_q.push_back(cur_line);
                  got_beats_q.push_back(beat_i);
                  got_last_q.push_back(last_pos);
               end
            end
         end
      end
   end

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW/32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic int find_youngest(input logic [LBW-1:0] lbl);
      int r;
      logic [ALLW-1:0] e;
      r = -1;
      for (int i = 0; i < mdl_q.size(); i++) begin
         e = mdl_q[i];
         if (e[LW +: LBW] == lbl) r = i;
      end
      return r;
   endfunction

   task automatic push_line(input logic [LBW-1:0] lbl, input logic [LW-1:0] dat,
                            input bit head_locked);
      bit coal, exp_acc;
      int m;
      logic [ALLW-1:0] e;
      coal = 0;
      m = find_youngest(lbl);
`ifdef WB_COALESCE_EN
      coal = (m >= 0) && !(m == 0 && head_locked);
`endif
      exp_acc = coal || (mdl_q.size() < D);
      @(negedge clk);
      pline = {lbl, dat}; push = 1; #2;
      check("pushed", pushed, exp_acc);
      @(posedge clk); #1;
      push = 0;
      if (coal) begin
         e = mdl_q[m]; e[LW-1:0] = dat; mdl_q[m] = e;
      end else if (exp_acc) begin
         mdl_q.push_back({lbl, dat});
      end
      if (head_locked && m < -1) check("unreachable", 0, 0);
   endtask

   task automatic query_check(input logic [LBW-1:0] lbl);
      int m;
      logic [ALLW-1:0] e;
      m = find_youngest(lbl);
      @(negedge clk);
      query_label = lbl; write = 0; #2;
      check("query_found", query_found, m >= 0);
      if (m >= 0) begin
         e = mdl_q[m];
         check("query_rdata", query_rdata, e[LW-1:0]);
      end else begin
         check("query_rdata_zero", query_rdata, '0);
      end
   endtask

   // Called only while a drain is under way, so the oldest entry is locked.
   task automatic merge(input logic [LBW-1:0] lbl, input logic [LW-1:0] wd, input logic [NB-1:0] be);
      int m;
      bit exp_w;
      logic [ALLW-1:0] e;
      m = find_youngest(lbl);
      exp_w = (m > 0);
      @(negedge clk);
      query_label = lbl; query_wdata = wd; query_wbe = be; write = 1; #2;
      check("merge_found", query_found, m >= 0);
      check("written", written, exp_w);
      @(posedge clk); #1;
      write = 0;
      if (exp_w) begin
         e = mdl_q[m];
         for (int b = 0; b < NB; b++) if (be[b]) e[8*b +: 8] = wd[8*b +: 8];
         mdl_q[m] = e;
      end
   endtask

   task automatic drain_and_compare();
      logic [ALLW-1:0] e;
      int n, cyc;
      exp_q = mdl_q;
      mdl_q.delete();
      n = exp_q.size();
      cyc = 0;
      while (got_data_q.size() < n && cyc < 4000) begin @(posedge clk); cyc++; end
      check("burst_count", got_data_q.size(), n);
      while (exp_q.size() > 0 && got_data_q.size() > 0) begin
         e = exp_q.pop_front();
         check("awaddr", got_addr_q.pop_front(), {e[LW +: LBW], 5'b0});
         check("burst_data", got_data_q.pop_front(), e[LW-1:0]);
         check("beats", got_beats_q.pop_front(), LW/32);
         check("wlast_pos", got_last_q.pop_front(), LW/32 - 1);
      end
      exp_q.delete();
      cyc = 0;
      while (!empty && cyc < 400) begin @(posedge clk); cyc++; end
      @(negedge clk); #2;
      check("drain_empty", empty, 1'b1);
      check("drain_full", full, 1'b0);
      check("extra_bursts", got_data_q.size(), 0);
      got_addr_q.delete(); got_data_q.delete(); got_beats_q.delete(); got_last_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, n, idx;
      logic [LBW-1:0]  lbl;
      logic [ALLW-1:0] e;
      logic [LW-1:0]   aa_line;
      logic [LW-1:0]   dup_a, dup_b;

      rst = 1; push = 0; write = 0; pline = '0; query_label = '0;
      query_wdata = '0; query_wbe = '0; mode = 0; beat_i = 0; aw_cycles = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      write = 1; query_label = 27'h10; #2;
      check("rst_full", full, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_query_found", query_found, 1'b0);
      check("rst_written", written, 1'b0);
      check("rst_awvalid", axi.awvalid, 1'b0);
      check("rst_wvalid", axi.wvalid, 1'b0);
      check("rst_bready", axi.bready, 1'b1);
      check("rst_state", dbg_state, 2'd0);
      write = 0;
      @(negedge clk);
      rst = 0;

      // Fill to DEPTH with the address channel held off.
      for (int i = 0; i < D; i++) push_line(27'h10 + LBW'(i), rand_line(), 1'b1);
      @(negedge clk); #2;
      check("fill_full", full, 1'b1);
      check("fill_awvalid", axi.awvalid, 1'b1);
      check("fill_awaddr", axi.awaddr, 32'h10 << 5);
      check("fill_awlen", axi.awlen, 4'd7);
      push_line(27'h14, rand_line(), 1'b1);
      for (int i = 0; i < D; i++) query_check(27'h10 + LBW'(i));
      query_check(27'h55);

      aa_line = {NB{8'hAA}};
      merge(27'h12, aa_line, 32'h0000000F);
      query_check(27'h12);
      merge(27'h10, rand_line(), '1);

      // Address accepted, data held: head is locked in the write phase.
      mode = 3;
      cyc = 0;
      while (!axi.wvalid && cyc < 50) begin @(negedge clk); #2; cyc++; end
      check("reach_write", axi.wvalid, 1'b1);
      merge(27'h10, rand_line(), 32'($urandom));
      query_check(27'h10);
      mode = 1;
      drain_and_compare();

      // Same label pushed twice back to back.
      mode = 0;
      dup_a = rand_line();
      dup_b = rand_line();
      push_line(27'h20, dup_a, 1'b0);
      push_line(27'h20, dup_b, 1'b0);
      query_check(27'h20);
`ifdef WB_COALESCE_EN
      check("dup_entries", mdl_q.size(), 1);
`else
      check("dup_entries", mdl_q.size(), 2);
`endif
      mode = 1;
      drain_and_compare();

      // Randomized rounds: random lines, merges and slave timing.
      for (int r = 0; r < 4; r++) begin
         mode = 0;
         n = $urandom_range(1, D);
         for (int i = 0; i < n; i++) begin
            lbl = LBW'({$urandom_range(1, 4000), 4'(r), 4'(i)});
            push_line(lbl, rand_line(), 1'b1);
         end
         if (n == D) push_line(27'h7FF_0000, rand_line(), 1'b1);
         repeat (2) @(posedge clk);
         for (int k = 0; k < 3; k++) begin
            idx = $urandom_range(0, mdl_q.size() - 1);
            e = mdl_q[idx];
            merge(e[LW +: LBW], rand_line(), 32'($urandom));
         end
         for (int k = 0; k < mdl_q.size(); k++) begin
            e = mdl_q[k];
            query_check(e[LW +: LBW]);
         end
         mode = 2;
         drain_and_compare();
      end

      // Reset during a burst.
      mode = 0;
      beat_i = 0;
      push_line(27'h30, rand_line(), 1'b1);
      push_line(27'h31, rand_line(), 1'b1);
      mode = 1;
      cyc = 0;
      while (beat_i < 3 && cyc < 100) begin @(negedge clk); #2; cyc++; end
      check("reach_beat3", beat_i >= 3, 1'b1);
      @(posedge clk); #2;
      rst = 1; #1;
      check("midrst_wvalid", axi.wvalid, 1'b0);
      check("midrst_empty", empty, 1'b1);
      check("midrst_full", full, 1'b0);
      check("midrst_awvalid", axi.awvalid, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
      mdl_q.delete();
      aw_cycles = 0;
      got_addr_q.delete(); got_data_q.delete(); got_beats_q.delete(); got_last_q.delete();
      repeat (20) @(posedge clk);
      check("postrst_aw_cycles", aw_cycles, 0);
      check("postrst_bursts", got_data_q.size(), 0);
      query_check(27'h30);
      @(negedge clk); #2;
      check("postrst_empty", empty, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
